// File: rtl/alu_defs.sv
// Shared definitions for the ALU arbiter: ALU control codes, FSM state
// encoding and the latency-count helper used when an operation is accepted.
package alu_defs;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Cycles still to wait after the first EXEC cycle; multiplies are the
  // only operation with their own latency, every other code (including the
  // undefined ones) uses the common one.
  function automatic logic [3:0] exec_count(input logic [2:0] ctrl,
                                            input logic [3:0] mul_cnt,
                                            input logic [3:0] op_cnt);
    return (ctrl == ALU_MUL) ? mul_cnt : op_cnt;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way request picker. Round-robin by default: on a tie the requester
// that was not granted last wins. With ALU_ARBITER_FIXED_PRIO_EN defined,
// requester 0 always wins a tie and the 'last' input is ignored.
module alu_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

`ifdef ALU_ARBITER_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: requester 0 wins whenever both ask.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = 2'b01;
  end
`else
  // Round-robin: a lone requester always wins, a tie goes to the other one.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = last ? 2'b01 : 2'b10;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 32-bit ALU between the EX stage (port 0) and the address/branch
// unit (port 1). One operation at a time: accept in IDLE, hold operands on
// the ALU for the op latency in EXEC, present the result in RESP.
// Optional macro ALU_ARBITER_FIXED_PRIO_EN selects fixed priority to port 0
// instead of round-robin.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int MUL_LAT = 3,
  parameter int OP_LAT  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [2:0]  req0_ctrl_i,
  input  logic [31:0] req0_data1_i,
  input  logic [31:0] req0_data2_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_data_o,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [2:0]  req1_ctrl_i,
  input  logic [31:0] req1_data1_i,
  input  logic [31:0] req1_data2_i,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_data_o,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_data_i,
  output logic        busy_o
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] OP_CNT  = 4'(OP_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [2:0]  op_ctrl_q;
  logic [31:0] op_data1_q;
  logic [31:0] op_data2_q;
  logic [31:0] result_q;
  logic        owner_q;
  logic [1:0]  grant;
  logic        pick_last;
  logic        rsp_done;
  logic [2:0]  sel_ctrl;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
  assign pick_last = 1'b1;
`else
  logic last_grant_q;
  assign pick_last = last_grant_q;
`endif

  alu_rr_pick u_pick (
    .valid (({req1_valid_i, req0_valid_i})),
    .last  (pick_last),
    .grant (grant)
  );

  assign sel_ctrl    = grant[1] ? req1_ctrl_i : req0_ctrl_i;
  assign rsp_done    = (state_q == RESP) && (owner_q ? rsp1_ready_i : rsp0_ready_i);
  assign alu_data1_o = op_data1_q;
  assign alu_data2_o = op_data2_q;
  assign alu_ctrl_o  = op_ctrl_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; ready is only offered in IDLE and
  // never while reset is asserted.
  always_comb begin
    state_d      = state_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    rsp0_data_o  = '0;
    rsp1_data_o  = '0;
    busy_o       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req0_ready_o = rst_i & grant[0];
        req1_ready_o = rst_i & grant[1];
        if (|grant) state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == 4'd0) state_d = RESP;
      end
      RESP: begin
        if (owner_q) begin
          rsp1_valid_o = 1'b1;
          rsp1_data_o  = result_q;
        end else begin
          rsp0_valid_o = 1'b1;
          rsp0_data_o  = result_q;
        end
        if (rsp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept, latency countdown and result capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q      <= '0;
      op_ctrl_q  <= '0;
      op_data1_q <= '0;
      op_data2_q <= '0;
      result_q   <= '0;
      owner_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            owner_q    <= grant[1];
            op_ctrl_q  <= sel_ctrl;
            op_data1_q <= grant[1] ? req1_data1_i : req0_data1_i;
            op_data2_q <= grant[1] ? req1_data2_i : req0_data2_i;
            cnt_q      <= exec_count(sel_ctrl, MUL_CNT, OP_CNT);
          end
        end
        EXEC: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          else               result_q <= alu_data_i;
        end
        default: ;
      endcase
    end
  end

`ifndef ALU_ARBITER_FIXED_PRIO_EN
  // Remember who was served last so the other requester wins the next tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        last_grant_q <= 1'b1;
    else if (rsp_done) last_grant_q <= owner_q;
  end
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters: port 0 is the EX stage and port 1 is the address/branch-target unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Sequences multi-cycle multiplies by holding ALU operands stable for a programmable latency.
- Sits between the requesters and the ALU; it drives the ALU's data1/data2/control inputs and samples its result.

Parameters:
- MUL_LAT, 3, ALU cycles held for control 3'b100 (mul); legal range 1..15.
- OP_LAT, 1, ALU cycles held for every other control code; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req0_valid_i  in  1  requester 0 has an operation.
- req0_ready_o  out  1  requester 0 operation accepted this cycle.
- req0_ctrl_i  in  3  ALU control code.
- req0_data1_i  in  32  operand 1.
- req0_data2_i  in  32  operand 2.
- rsp0_valid_o  out  1  result for requester 0 is available.
- rsp0_ready_i  in  1  requester 0 consumes the result.
- rsp0_data_o  out  32  result.
- req1_* / rsp1_*: same as the port 0 signals, for requester 1.
- alu_data1_o  out  32  to ALU data1_i.
- alu_data2_o  out  32  to ALU data2_i.
- alu_ctrl_o  out  3  to ALU ALUControl_i.
- alu_data_i  in  32  from ALU data_o.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_i=0):
  - state=IDLE, last_grant=1 so requester 0 wins the first tie.
  - Operand, control, result and counter registers cleared to 0.
  - All ready, valid and busy outputs 0; alu_* outputs 0.
  - An operation in flight is dropped and no response is ever produced for it.
- ALU drive: alu_data1_o, alu_data2_o and alu_ctrl_o always come from the registered operands. They are constant across EXEC and RESP.
- IDLE:
  - grant = the only valid requester; if both are valid, the requester that is not last_grant.
  - reqN_ready_o = 1 only for the granted requester. It is combinational from valid and state, and is 0 in every other state.
  - On the handshake (valid & ready): latch ctrl, data1, data2 and owner; load cnt = latency-1, where latency = MUL_LAT for ctrl 3'b100, else OP_LAT; go to EXEC.
  - A requester that drops valid without a handshake loses nothing.
- EXEC:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, register alu_data_i into the result register and go to RESP.
- RESP:
  - rspN_valid_o = 1 for the owner only; rspN_data_o = result.
  - rspN_data_o is 0 for the non-owner and outside RESP.
  - Stay in RESP until rspN_ready_i is high, then set last_grant = owner and go to IDLE.
- Latency:
  - Handshake in cycle 0; EXEC occupies cycles 1..latency; rsp_valid rises in cycle latency+1.
  - Minimum spacing between accepted operations is latency+2 cycles; no overlap.
- Control codes:
  - Undefined codes 011 and 101 are passed to the ALU unchanged, use OP_LAT, and return whatever the ALU produces (0).
  - The arbiter does not check or alter any arithmetic.
- Simultaneous events:
  - A rsp_ready held high from before RESP completes in the first RESP cycle.
  - A new request arriving during RESP waits until IDLE.
  - Requests from the response's owner are treated identically to the other requester's.

Optional Feature:
- Macro ALU_ARBITER_FIXED_PRIO_EN.
- Defined: requester 0 always wins a tie; last_grant is not implemented.
- Undefined: round-robin as described above.

Decomposition:
- Shared package/include alu_defs:
  - ALU control constants ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_MUL=100, ALU_SUB=110, ALU_SLT=111.
  - State encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One natural sub-module: alu_rr_pick.
  - 2-way round-robin picker: inputs valid[1:0] and last; output grant one-hot.
  - Compiled to fixed priority under the macro.

Test Plan:
- Reset then req0 ADD 5+7 (ctrl 010), rsp0_ready=1: ready0 in cycle 0, rsp0_valid in cycle 2 with data 12, busy_o for cycles 1..2.
- req1 MUL 6*7 (ctrl 100), MUL_LAT=3: alu_ctrl_o=100 stable in cycles 1..3, rsp1_valid in cycle 4 with data 42.
- Both valid continuously with SUB 10-3 and SLT 2<9:
  - Default build: grants alternate 0,1,0,1 with results 7,1,7,1.
  - With ALU_ARBITER_FIXED_PRIO_EN: requester 0 is always granted.
- rsp0_ready held low for 5 cycles: rsp0_valid and data stay stable, req1_ready stays 0, and IDLE is re-entered the cycle after ready rises.
- rst_i pulsed low mid-EXEC of a MUL: all outputs go 0 immediately, no rsp_valid ever appears for it, and the next request is accepted normally.
- Undefined ctrl 011 with 3,4: rsp_valid in cycle 2 with data 0.
